// File: rtl/game_state_ctrl.sv
// Game phase controller: debounced jump, INIT/START/END/RESET sequencing, BCD score.
// HIGH_SCORE_EN builds the best-score register; otherwise high_score is tied to zero.
module game_state_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 100000,
    parameter int RESET_HOLD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_jump,
    input  logic        btn_reset,
    input  logic        collision,
    input  logic        game_tick,
    output logic [1:0]  game_state,
    output logic        jump_pulse,
    output logic [15:0] score,
    output logic [15:0] high_score
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_START = 2'd1,
        ST_END   = 2'd2,
        ST_RESET = 2'd3
    } state_e;

    localparam int              DB_W      = 20;
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]      HOLD_LAST = 8'(RESET_HOLD_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            db_level_q, db_level_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            jump_pulse_q, jump_pulse_d;
    state_e          state_q, state_d;
    logic [7:0]      hold_q, hold_d;
    logic [15:0]     score_q, score_d;
    logic            tick_q;
    logic            tick_rise;

    // Saturating 4-digit BCD increment; 9999 is sticky.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return (v == 16'h9999) ? v : r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            db_level_q   <= 1'b0;
            db_cnt_q     <= '0;
            jump_pulse_q <= 1'b0;
            state_q      <= ST_INIT;
            hold_q       <= '0;
            score_q      <= '0;
            tick_q       <= 1'b0;
        end else begin
            sync1_q      <= btn_jump;
            sync2_q      <= sync1_q;
            db_level_q   <= db_level_d;
            db_cnt_q     <= db_cnt_d;
            jump_pulse_q <= jump_pulse_d;
            state_q      <= state_d;
            hold_q       <= hold_d;
            score_q      <= score_d;
            tick_q       <= game_tick;
        end
    end

    // The pulse is raised on the same edge the accepted level rises.
    always_comb begin
        db_level_d   = db_level_q;
        db_cnt_d     = db_cnt_q;
        jump_pulse_d = 1'b0;
        if (sync2_q == db_level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_level_d   = sync2_q;
            db_cnt_d     = '0;
            jump_pulse_d = sync2_q;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    assign tick_rise = game_tick & ~tick_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        score_d = score_q;
        unique case (state_q)
            ST_INIT: begin
                score_d = '0;
                if (jump_pulse_q) state_d = ST_START;
            end
            ST_START: begin
                if (tick_rise) score_d = bcd_inc(score_q);
                if (collision) state_d = ST_END;
            end
            ST_END: begin
                if (jump_pulse_q) begin
                    state_d = ST_RESET;
                    hold_d  = '0;
                    score_d = '0;
                end
            end
            ST_RESET: begin
                score_d = '0;
                if (hold_q == HOLD_LAST) state_d = ST_INIT;
                else                     hold_d  = hold_q + 8'd1;
            end
        endcase
        if (btn_reset) begin
            state_d = ST_RESET;
            hold_d  = '0;
            score_d = '0;
        end
    end

`ifdef HIGH_SCORE_EN
    logic [15:0] high_q, high_d;

    // Packed BCD orders the same as its binary value, so a plain compare works.
    always_comb begin
        high_d = high_q;
        if (state_q == ST_START && state_d == ST_END && score_d > high_q) high_d = score_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) high_q <= '0;
        else     high_q <= high_d;
    end

    assign high_score = high_q;
`else
    assign high_score = 16'h0000;
`endif

    assign game_state = state_q;
    assign jump_pulse = jump_pulse_q;
    assign score      = score_q;

endmodule
